// File: rtl/uart_pkg.sv
// uart_pkg: UART constants, state encoding and divisor/width helpers.
// It is shared by the receiver and the planned transmitter.
package uart_pkg;

    localparam int DATA_W = 8;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;
    localparam logic [2:0] BREAK  = 3'd5;

    // Rounded clk/(baud*oversample).
    function automatic int baud_div(input longint clk_hz, input longint baud, input longint os);
        return int'((clk_hz + (baud * os) / 2) / (baud * os));
    endfunction

    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divide-by-DIV counter with a one-cycle tick.
// Synchronous clr restarts the count so the tick phase follows an external event.
module uart_baud_tick import uart_pkg::*; #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int W = cnt_w(DIV);

    logic [W-1:0] cnt;

    assign tick = cnt == W'(DIV - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= (clr || tick) ? '0 : cnt + W'(1);
    end

endmodule

// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: oversampling UART receiver with a one-entry valid/ready holding register.
// Define UART_RX_PARITY_EN for 8E1 frames with parity checking; the default build is 8N1.
module uart_rx_frontend import uart_pkg::*; #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rxd,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              frame_err,
    output logic              overrun,
    output logic              parity_err
);

    localparam int DIV = baud_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int TW  = cnt_w(OVERSAMPLE);
    localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_FULL = TW'(OVERSAMPLE - 1);
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] AFTER_DATA = PARITY;
`else
    localparam logic [2:0] AFTER_DATA = STOP;
`endif

    logic              s1, rxs, rxs_d;
    logic [2:0]        state;
    logic [TW-1:0]     tcnt;
    logic [2:0]        bcnt;
    logic [DATA_W-1:0] shift;
    logic              tick, clr, bit_end, stop_ok, stop_bad, hold;

    assign clr      = state == IDLE && rxs_d && !rxs;
    assign bit_end  = tick && tcnt == ((state == START) ? T_HALF : T_FULL);
    assign stop_ok  = state == STOP && bit_end && rxs;
    assign stop_bad = state == STOP && bit_end && !rxs;
    assign hold     = rx_valid && !rx_ready;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 1'b1;
            rxs   <= 1'b1;
            rxs_d <= 1'b1;
            state <= IDLE;
            tcnt  <= '0;
            bcnt  <= '0;
            shift <= '0;
        end else begin
            s1    <= rxd;
            rxs   <= s1;
            rxs_d <= rxs;
            tcnt  <= (state == IDLE || bit_end) ? '0 : tcnt + TW'(tick);
            case (state)
                IDLE:   if (clr) state <= START;
                START:  if (bit_end) begin
                    state <= rxs ? IDLE : DATA;
                    bcnt  <= '0;
                end
                DATA:   if (bit_end) begin
                    shift[bcnt] <= rxs;
                    bcnt        <= bcnt + 3'd1;
                    if (bcnt == 3'd7) state <= AFTER_DATA;
                end
                PARITY: if (bit_end) state <= STOP;
                STOP:   if (bit_end) state <= rxs ? IDLE : BREAK;
                BREAK:  if (rxs) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // A full register that is not draining keeps its byte; the new one is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= stop_ok && hold;
            rx_valid  <= stop_ok || hold;
            if (stop_ok && !hold) rx_data <= shift;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (state == PARITY && bit_end) par_bit <= rxs;
            parity_err <= stop_ok && (par_bit != ^shift);
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frontend.sv
// tb_uart_rx_frontend: directed frames against a cycle-accurate delivery schedule model.
module tb_uart_rx_frontend;

    localparam int BIT = 432;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 4539;
`else
    localparam int LAT = 4107;
`endif

    typedef struct {
        int         at;
        logic [7:0] d;
        bit         fe;
        bit         pe;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun, parity_err;

    int  cyc = 0;
    int  vec = 0, bad = 0;
    int  fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, vr_cnt = 0;
    ev_t q[$];

    logic       m_valid = 1'b0;
    logic [7:0] m_data = 8'h00;
    bit         p_acc = 1'b0;
    logic       prev_valid = 1'b0;

    uart_rx_frontend dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .parity_err(parity_err)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            bad++;
            if (bad <= 20) $display("FAIL %s at cycle %0d: got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic at_cyc(input int c);
        while (cyc != c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic v, input int bits);
        rxd = v;
        idle(bits * BIT);
    endtask

    // Stop sample lands 2 sync + 1 edge-detect cycles plus 9.5 (10.5 with parity) bits after the fall.
    task automatic send_frame(input logic [7:0] d, input bit stop, input bit par_flip);
        ev_t e;
        e.at = cyc + LAT;
        e.d  = d;
        e.fe = !stop;
        e.pe = 1'b0;
`ifdef UART_RX_PARITY_EN
        e.pe = par_flip;
`endif
        q.push_back(e);
        drive(1'b0, 1);
        for (int i = 0; i < 8; i++) drive(d[i], 1);
`ifdef UART_RX_PARITY_EN
        drive((^d) ^ par_flip, 1);
`endif
        drive(stop, 1);
    endtask

    always @(negedge clk) begin
        ev_t  e;
        logic e_fe, e_ov, e_pe;
        bit   loaded;
        e_fe = 1'b0;
        e_ov = 1'b0;
        e_pe = 1'b0;
        loaded = 1'b0;
        if (!rst_n) begin
            q.delete();
            m_valid = 1'b0;
            m_data  = 8'h00;
            p_acc   = 1'b0;
        end else begin
            if (q.size() > 0 && q[0].at == cyc) begin
                e = q.pop_front();
                if (e.fe) e_fe = 1'b1;
                else begin
                    e_pe = e.pe;
                    if (m_valid && !p_acc) e_ov = 1'b1;
                    else begin
                        m_data  = e.d;
                        m_valid = 1'b1;
                        loaded  = 1'b1;
                    end
                end
            end
            if (p_acc && !loaded) m_valid = 1'b0;
            p_acc = m_valid && rx_ready;
        end
        cmp("rx_valid", rx_valid, m_valid);
        cmp("rx_data", rx_data, m_data);
        cmp("frame_err", frame_err, e_fe);
        cmp("overrun", overrun, e_ov);
        cmp("parity_err", parity_err, e_pe);
        if (frame_err === 1'b1) fe_cnt++;
        if (overrun === 1'b1) ov_cnt++;
        if (parity_err === 1'b1) pe_cnt++;
        if (rx_valid === 1'b1 && !prev_valid) vr_cnt++;
        prev_valid = rx_valid;
    end

    initial begin
        int n;
        idle(3);
        rst_n = 1'b1;
        idle(10);
        cmp("reset rx_data", rx_data, 8'h00);
        cmp("reset rx_valid", rx_valid, 1'b0);

        n = cyc;
        fork
            send_frame(8'hA5, 1'b1, 1'b0);
            begin
                at_cyc(n + LAT - 1);
                #5 cmp("a5 not yet valid", rx_valid, 1'b0);
                at_cyc(n + LAT);
                #5 cmp("a5 valid", rx_valid, 1'b1);
                cmp("a5 data", rx_data, 8'hA5);
            end
        join
        idle(BIT);

        send_frame(8'h3C, 1'b0, 1'b0);
        drive(1'b0, 2);
        drive(1'b1, 1);
        cmp("framing fe pulses", fe_cnt, 1);
        cmp("framing no delivery", vr_cnt, 1);
        send_frame(8'h55, 1'b1, 1'b0);
        idle(50);
        cmp("55 after break", rx_data, 8'h55);
        cmp("55 delivered", vr_cnt, 2);

        rxd = 1'b0;
        idle(150);
        rxd = 1'b1;
        idle(2 * BIT);
        cmp("glitch no fe", fe_cnt, 1);
        cmp("glitch no valid", vr_cnt, 2);

        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        cmp("overrun keeps 11", rx_data, 8'h11);
        cmp("overrun pulses", ov_cnt, 1);
        n = cyc;
        fork
            send_frame(8'h33, 1'b1, 1'b0);
            begin
                at_cyc(n + LAT - 1);
                rx_ready = 1'b1;
                at_cyc(n + LAT);
                #5 cmp("33 swap valid", rx_valid, 1'b1);
                cmp("33 swap data", rx_data, 8'h33);
            end
        join
        idle(50);
        cmp("no overrun on swap", ov_cnt, 1);
        cmp("swap no new rise", vr_cnt, 3);

        rx_ready = 1'b0;
        drive(1'b0, 5);
        rxd = 1'b1;
        idle(200);
        rst_n = 1'b0;
        #2;
        cmp("async rst rx_data", rx_data, 8'h00);
        cmp("async rst rx_valid", rx_valid, 1'b0);
        cmp("async rst flags", {frame_err, overrun, parity_err}, 3'b000);
        idle(5);
        rst_n = 1'b1;
        idle(2 * BIT);
        cmp("rst no fe", fe_cnt, 1);
        cmp("rst no valid", vr_cnt, 3);
        rx_ready = 1'b1;
        send_frame(8'h0F, 1'b1, 1'b0);
        idle(50);
        cmp("0f after reset", rx_data, 8'h0F);
        cmp("0f delivered", vr_cnt, 4);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        idle(50);
        cmp("07 good parity", pe_cnt, 0);
        send_frame(8'h07, 1'b1, 1'b1);
        idle(50);
        cmp("07 bad parity", pe_cnt, 1);
        cmp("07 still delivered", vr_cnt, 6);
`endif

        idle(20);
        cmp("no pending events", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_frontend.md
Name: uart_rx_frontend

Overview:
- UART receiver for the URXD pin; sits directly upstream of the top-level command/display logic and feeds it received bytes.
- Synchronises the asynchronous serial line and oversamples each bit.
- Validates the start bit and checks the stop bit (and, optionally, parity).
- Presents each byte through a one-entry valid/ready holding register with error flags.
- Board clock is 50 MHz; default line format is 115200 baud, 8N1, LSB first.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- OVERSAMPLE, 16, baud ticks per bit; must be even and >= 8.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rxd  input  1  raw serial line (URXD); idle high.
- rx_data  output  8  received byte; valid while rx_valid=1.
- rx_valid  output  1  holding register full.
- rx_ready  input  1  consumer accepts the byte when rx_valid & rx_ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: byte completed while the holding register was full and not being drained.
- parity_err  output  1  one-cycle pulse on parity mismatch; tied 0 when parity is not compiled in.

Behaviour:
- Clock and reset: one clock (clk); rst_n is asynchronous assert, active low. Release is synchronous to clk by the integrator.
- Reset values:
  - rx_data=0x00, rx_valid=0, frame_err=0, overrun=0, parity_err=0.
  - Synchroniser flops=1; state=IDLE; all counters=0.
- Input synchroniser: 2-flop on rxd, reset to 1. All logic uses the second-flop output rxs. Adds 2 cycles of latency.
- Tick generator:
  - DIV = round(CLK_HZ/(BAUD*OVERSAMPLE)), which is 27 at the defaults.
  - Counter 0..DIV-1 emits a one-cycle tick; one bit = 432 clk = 8640 ns.
  - Counter is cleared on entry to START so sampling phase aligns to the falling edge.
- State machine (advances only on ticks, except the IDLE edge detect):
  - IDLE: on rxs falling edge (prev 1, now 0), go to START with tick_cnt=0.
  - START: after OVERSAMPLE/2 ticks, sample rxs.
    - If 0: go to DATA with bit_cnt=0, tick_cnt=0.
    - If 1: glitch; return to IDLE and flag nothing.
  - DATA: every OVERSAMPLE ticks, sample rxs into shift[bit_cnt], LSB first. After bit 7, go to PARITY if compiled in, else STOP.
  - PARITY (optional): sample one bit after OVERSAMPLE ticks, then go to STOP.
  - STOP: sample after OVERSAMPLE ticks.
    - If 1: deliver the byte, go to IDLE.
    - If 0: pulse frame_err, discard the byte, go to BREAK.
  - BREAK: wait for rxs=1, then go to IDLE. No new start is detected while the line is held low.
- Delivery:
  - The cycle after the stop-sample tick: rx_data <= shift, rx_valid <= 1.
  - rx_data is stable while rx_valid=1.
  - rx_valid clears the cycle after rx_valid & rx_ready, unless a new byte is delivered in that same cycle.
- Simultaneous accept and delivery: the new byte is loaded, rx_valid stays 1, and there is no overrun.
- Delivery while full and not accepted: pulse overrun, drop the new byte, keep the old one.
- Error priority: frame_err suppresses delivery, overrun and parity_err for that frame.
- Reset mid-frame: immediate return to reset values; the partial byte is lost; no flags are asserted.
- Consecutive frames: a start bit immediately following the stop-bit sample is detected, giving full back-to-back throughput.

Optional Feature:
- UART_RX_PARITY_EN defined:
  - Frame is 8E1; the even-parity bit follows the data.
  - On mismatch, parity_err pulses together with the delivery cycle; the byte is still delivered.
- UART_RX_PARITY_EN undefined:
  - No PARITY state; parity_err is constant 0.
  - Frame is 8N1.

Decomposition:
- Shared package uart_pkg:
  - State encoding (IDLE, START, DATA, PARITY, STOP, BREAK).
  - DATA_W=8.
  - Divisor computation function.
  - Width helper for clog2 of DIV and OVERSAMPLE.
  - Reused by the future uart_tx.
- Sub-module uart_baud_tick: parameterised divisor counter with a synchronous clear input and a tick output. Shared with the transmitter.

Test Plan:
- Normal byte: send 0xA5 at 8640 ns/bit with rx_ready=1.
  - rx_valid pulses with rx_data=0xA5, ~9.5 bits (~82 us) after the start edge.
  - No error flags.
- Framing error: send 0x3C with the stop bit low, then hold the line low for 2 bit times.
  - frame_err pulses once; rx_valid stays 0.
  - The next frame, 0x55, after the line returns high is received correctly.
- Glitch rejection: rxd low for 3 us (less than half a bit), then high.
  - No rx_valid and no frame_err; state returns to IDLE.
- Overrun and back-to-back handshake: rx_ready=0; send 0x11 then 0x22 back-to-back.
  - rx_data holds 0x11; overrun pulses at the second delivery.
  - Then raise rx_ready in the exact cycle a third byte 0x33 is delivered: rx_data=0x33, rx_valid stays 1, no overrun.
- Reset mid-frame: assert rst_n=0 during data bit 4 of 0xF0.
  - All outputs reach reset values asynchronously; no flags.
  - Next frame 0x0F is received intact.
- Parity (UART_RX_PARITY_EN only): send 0x07 with parity=1 (correct) → delivered, parity_err=0.
  - Send 0x07 with parity=0 → delivered with a parity_err pulse in the delivery cycle.
